// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcode/funct values,
// ALU and extender codes, FSM state encoding and the decoder's output bundle.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_OR  = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_LUI = 5'd6;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL, C_ILL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [4:0] alu_ctr;
    logic       alu_src;
    logic [1:0] ext_op;
    logic       reg_dst;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct -> instruction class plus
// the static datapath controls that stay fixed for the whole instruction.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.cls     = C_ILL;
    dec.alu_ctr = ALU_ADD;
    dec.alu_src = 1'b0;
    dec.ext_op  = EXT_ZERO;
    dec.reg_dst = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.cls     = C_R;
        dec.reg_dst = 1'b1;
        case (funct)
          FN_ADDU: dec.alu_ctr = ALU_ADD;
          FN_SUBU: dec.alu_ctr = ALU_SUB;
          FN_AND:  dec.alu_ctr = ALU_AND;
          FN_OR:   dec.alu_ctr = ALU_OR;
          FN_SLT:  dec.alu_ctr = ALU_SLT;
          FN_SLL:  dec.alu_ctr = ALU_SLL;
          FN_JR: begin
            dec.cls     = C_JR;
            dec.reg_dst = 1'b0;
          end
          default: begin
            dec.cls     = C_ILL;
            dec.reg_dst = 1'b0;
          end
        endcase
      end
      OP_ORI: begin
        dec.cls     = C_ORI;
        dec.alu_ctr = ALU_OR;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_ZERO;
      end
      OP_LW, OP_SW: begin
        dec.cls     = (opcode == OP_LW) ? C_LW : C_SW;
        dec.alu_ctr = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_SIGN;
      end
      OP_BEQ: begin
        dec.cls     = C_BEQ;
        dec.alu_ctr = ALU_SUB;
        dec.ext_op  = EXT_SIGN;
      end
      OP_LUI: begin
        dec.cls     = C_LUI;
        dec.alu_ctr = ALU_LUI;
        dec.alu_src = 1'b1;
        dec.ext_op  = EXT_LUI;
      end
      OP_J:    dec.cls = C_J;
      OP_JAL:  dec.cls = C_JAL;
      default: dec.cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: IF/ID/EXE/MEM/WB sequencer producing every
// datapath control input, plus a retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegDst,
  output logic             RegWr,
  output logic             ALUSrc,
  output logic             MemWr,
  output logic             MemtoReg,
  output logic [1:0]       ExtOp,
  output logic [4:0]       ALUctr,
  output logic             Branch,
  output logic             Jump,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  dec_t             dec;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             unused_ir_bits;

  assign unused_ir_bits = ^instruction[25:6];

  mc_decode u_decode (
    .opcode (instruction[31:26]),
    .funct  (instruction[5:0]),
    .dec    (dec)
  );

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (dec.cls inside {C_J, C_JAL, C_ILL}) ? S_IF : S_EXE;
      S_EXE: begin
        if (dec.cls inside {C_LW, C_SW})             state_d = S_MEM;
        else if (dec.cls inside {C_R, C_ORI, C_LUI}) state_d = S_WB;
        else                                         state_d = S_IF;
      end
      S_MEM: state_d = (dec.cls == C_LW) ? S_WB : S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Enables come from the state register; reset masks everything so an
  // abandoned instruction can never write.
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegDst   = 1'b0;
    RegWr    = 1'b0;
    ALUSrc   = 1'b0;
    MemWr    = 1'b0;
    MemtoReg = 1'b0;
    ExtOp    = EXT_ZERO;
    ALUctr   = ALU_ADD;
    Branch   = 1'b0;
    Jump     = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      if (state_q inside {S_EXE, S_MEM, S_WB}) begin
        ALUSrc = dec.alu_src;
        ExtOp  = dec.ext_op;
        ALUctr = dec.alu_ctr;
      end
      case (state_q)
        S_IF: IRWr = 1'b1;
        S_ID: begin
          if (dec.cls inside {C_J, C_JAL}) begin
            PCWr  = 1'b1;
            Jump  = 1'b1;
            RegWr = (dec.cls == C_JAL);
          end else if (dec.cls == C_ILL) begin
            PCWr    = 1'b1;
            illegal = 1'b1;
          end
        end
        S_EXE: begin
          if (dec.cls == C_BEQ) begin
            PCWr   = 1'b1;
            Branch = 1'b1;
          end else if (dec.cls == C_JR) begin
            PCWr = 1'b1;
            Jump = 1'b1;
          end
        end
        S_MEM: begin
          if (dec.cls == C_SW) begin
            PCWr  = 1'b1;
            MemWr = 1'b1;
          end
        end
        S_WB: begin
          PCWr     = 1'b1;
          RegWr    = 1'b1;
          MemtoReg = (dec.cls == C_LW);
          RegDst   = dec.reg_dst;
        end
        default: ;
      endcase
    end
  end

  assign instr_done = PCWr;
  assign retired    = retired_q;
  assign retired_d  = PCWr ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle schedules derived
// from the instruction class, compared cycle by cycle against two DUT widths.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;

  logic PCWr, IRWr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg, Branch, Jump, instr_done, illegal;
  logic [1:0]  ExtOp;
  logic [4:0]  ALUctr;
  logic [31:0] retired;

  logic PCWr_4, IRWr_4, RegDst_4, RegWr_4, ALUSrc_4, MemWr_4, MemtoReg_4, Branch_4, Jump_4;
  logic instr_done_4, illegal_4;
  logic [1:0] ExtOp_4;
  logic [4:0] ALUctr_4;
  logic [3:0] retired_4;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_ret = 32'h0;

  localparam int K_R = 0, K_JR = 1, K_ORI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
  localparam int K_LUI = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .PCWr(PCWr), .IRWr(IRWr), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc(ALUSrc),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .ExtOp(ExtOp), .ALUctr(ALUctr),
    .Branch(Branch), .Jump(Jump), .instr_done(instr_done), .illegal(illegal),
    .retired(retired)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instruction(instruction),
    .PCWr(PCWr_4), .IRWr(IRWr_4), .RegDst(RegDst_4), .RegWr(RegWr_4), .ALUSrc(ALUSrc_4),
    .MemWr(MemWr_4), .MemtoReg(MemtoReg_4), .ExtOp(ExtOp_4), .ALUctr(ALUctr_4),
    .Branch(Branch_4), .Jump(Jump_4), .instr_done(instr_done_4), .illegal(illegal_4),
    .retired(retired_4)
  );

  wire [17:0] obs  = {PCWr, IRWr, RegDst, RegWr, ALUSrc, MemWr, MemtoReg, ExtOp, ALUctr,
                      Branch, Jump, instr_done, illegal};
  wire [17:0] obs4 = {PCWr_4, IRWr_4, RegDst_4, RegWr_4, ALUSrc_4, MemWr_4, MemtoReg_4, ExtOp_4,
                      ALUctr_4, Branch_4, Jump_4, instr_done_4, illegal_4};

  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    case (op)
      6'h00: begin
        if (fn == 6'h08) return K_JR;
        if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00}) return K_R;
        return K_ILL;
      end
      6'h0D: return K_ORI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h0F: return K_LUI;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  // {ALUSrc, ExtOp, ALUctr} for the instruction
  function automatic logic [7:0] alu_fields(input logic [31:0] ins);
    logic [5:0] fn = ins[5:0];
    case (classify(ins))
      K_R: begin
        case (fn)
          6'h21:   return {1'b0, 2'b00, 5'd0};
          6'h23:   return {1'b0, 2'b00, 5'd1};
          6'h24:   return {1'b0, 2'b00, 5'd3};
          6'h25:   return {1'b0, 2'b00, 5'd2};
          6'h2A:   return {1'b0, 2'b00, 5'd4};
          default: return {1'b0, 2'b00, 5'd5};
        endcase
      end
      K_ORI:       return {1'b1, 2'b00, 5'd2};
      K_LW, K_SW:  return {1'b1, 2'b01, 5'd0};
      K_BEQ:       return {1'b0, 2'b01, 5'd1};
      K_LUI:       return {1'b1, 2'b10, 5'd6};
      default:     return 8'h00;
    endcase
  endfunction

  function automatic int last_cycle(input int cls);
    if (cls == K_J || cls == K_JAL || cls == K_ILL) return 2;
    if (cls == K_BEQ || cls == K_JR) return 3;
    if (cls == K_LW) return 5;
    return 4;
  endfunction

  // Expected output vector in cycle k (1 = IF) of an instruction.
  function automatic logic [17:0] exp_out(input logic [31:0] ins, input int k);
    int cls = classify(ins);
    int last = last_cycle(cls);
    logic pc = 0, ir = 0, rd = 0, rw = 0, mw = 0, mr = 0, br = 0, jp = 0, dn = 0, il = 0;
    logic [7:0] af = 8'h00;
    if (k == 1) ir = 1'b1;
    if (k >= 3) af = alu_fields(ins);
    if (k == last) begin
      pc = 1'b1;
      dn = 1'b1;
      rw = (cls == K_R || cls == K_ORI || cls == K_LUI || cls == K_LW || cls == K_JAL);
      mw = (cls == K_SW);
      mr = (cls == K_LW);
      rd = (cls == K_R);
      br = (cls == K_BEQ);
      jp = (cls == K_J || cls == K_JAL || cls == K_JR);
      il = (cls == K_ILL);
    end
    return {pc, ir, rd, rw, af[7], mw, mr, af[6:5], af[4:0], br, jp, dn, il};
  endfunction

  // Entered #1 after the edge that starts the IF cycle; leaves likewise.
  task automatic run_instr(input logic [31:0] ins, input string tag);
    int last = last_cycle(classify(ins));
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_out(ins, k) || obs4 !== exp_out(ins, k)) begin
        n_fail++;
        $display("FAIL %s_outputs cycle %0d ins=%h: got %h/%h expected %h",
                 tag, k, ins, obs, obs4, exp_out(ins, k));
      end
      n_tests++;
      if (retired !== model_ret || retired_4 !== model_ret[3:0]) begin
        n_fail++;
        $display("FAIL %s_retired cycle %0d: got %0d/%0d expected %0d/%0d",
                 tag, k, retired, retired_4, model_ret, model_ret[3:0]);
      end
      @(posedge clk);
      #1;
      if (k == 1) instruction = ins;
    end
    model_ret = model_ret + 32'd1;
    $display("[TB] %s ins=%h cycles=%0d retired_model=%0d", tag, ins, last, model_ret);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instruction = 32'h8C220004;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (obs !== 18'h0 || obs4 !== 18'h0 || retired !== 32'h0 || retired_4 !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_state: outputs %h/%h retired %0d/%0d expected all zero",
                 obs, obs4, retired, retired_4);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 32'h0;
    $display("[TB] reset released");
  endtask

  task automatic test_directed();
    run_instr(32'h8C220004, "lw");
    run_instr(32'hAC220008, "sw");
    run_instr(32'h10220003, "beq");
    run_instr(32'h08000010, "j");
    run_instr(32'h0C000010, "jal");
    run_instr(32'hFC000000, "illegal_op");
    run_instr(32'h00221817, "illegal_funct");
    run_instr(32'h03E00008, "jr");
    run_instr(32'h3C011234, "lui");
    run_instr(32'h34215678, "ori");
    run_instr(32'h00221823, "subu");
  endtask

  task automatic test_random();
    logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h02, 6'h03, 6'h3F};
    logic [5:0] fns [8]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08, 6'h3E};
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 10)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 7)];
      run_instr(ins, "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins = 32'h00221821;
    @(negedge clk);
    n_tests++;
    if (obs !== exp_out(ins, 1)) begin
      n_fail++;
      $display("FAIL midrst_if: got %h expected %h", obs, exp_out(ins, 1));
    end
    @(posedge clk);
    #1;
    instruction = ins;
    @(posedge clk);
    #1;
    reset = 1'b1;  // now in EXE of addu
    @(negedge clk);
    n_tests++;
    if (obs !== 18'h0 || obs4 !== 18'h0) begin
      n_fail++;
      $display("FAIL midrst_exe_outputs: got %h/%h expected 0", obs, obs4);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 32'h0;
    $display("[TB] reset during EXE of addu");
    run_instr(ins, "after_reset");
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_ret = 32'h0;
    for (int i = 0; i < 16; i++) begin
      run_instr((i % 2 == 0) ? 32'h08000010 : 32'h00221821, "wrap");
    end
    @(negedge clk);
    n_tests++;
    if (retired_4 !== 4'h0 || retired !== 32'd16) begin
      n_fail++;
      $display("FAIL wrap: retired %0d/%0d expected 16/0", retired, retired_4);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
